seg7_scan_ctrl: RTL
===================

Name: seg7_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment scanner; next generation of the board's 8-digit hex display driver.
- Drives NUM_DIGITS hex digits split across two segment buses, as on the EGO1 board: upper group on seg, lower group on seg1.
- Adds over the previous generation:
  - synchronous reset
  - tear-free frame snapshot
  - per-digit enable and decimal point
  - leading-zero blanking
  - 16-level PWM brightness
  - frame-done strobe
- Sits between the CPU MMIO display register and the board pins.

Parameters:
- NUM_DIGITS, 8, digit count; even, 2..16.
- DIV_MAX, 50000, system clocks per digit slot; minimum 2.
- BLINK_FRAMES, 32, full scan frames per blink half-period; used only with SEG7_BLINK_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- show_data  in  4*NUM_DIGITS  hex nibbles; digit i = show_data[4i+3:4i]
- dp_mask  in  NUM_DIGITS  1 = light decimal point of digit i
- digit_en  in  NUM_DIGITS  1 = digit i may light
- blank_lz  in  1  1 = suppress leading zeros
- brightness  in  4  PWM level 0 (1/16 on) .. 15 (always on)
- blink_mask  in  NUM_DIGITS  digits that blink; ignored without SEG7_BLINK_EN
- seg  out  8  segments, upper group, digits NUM_DIGITS/2 .. NUM_DIGITS-1
- seg1  out  8  segments, lower group, digits 0 .. NUM_DIGITS/2-1
- an  out  NUM_DIGITS  one-hot digit select, active-high
- frame_done  out  1  one-cycle pulse at end of each full scan

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on any clk edge with rst=1:
  - all counters and shadow registers clear to 0
  - an=0, seg=0, seg1=0, frame_done=0
  - applies equally mid-scan; no partial state survives.
- Prescaler:
  - div_cnt counts 0..DIV_MAX-1, then wraps.
  - tick is asserted on the cycle div_cnt==DIV_MAX-1.
- Digit counter:
  - cur advances on tick: 0,1,..,NUM_DIGITS-1, then wraps to 0.
  - Scan order: digit 0 first.
- Frame snapshot:
  - On a tick with cur==NUM_DIGITS-1, copy show_data, dp_mask, digit_en and blank_lz into shadow registers.
  - frame_done is registered high for exactly the following cycle.
  - Input changes mid-frame are never visible until the next frame.
  - After reset the shadows are 0, so the first frame is dark.
- PWM:
  - 4-bit pwm_cnt increments every clk and wraps 15->0.
  - lit_pwm = (pwm_cnt <= brightness).
- Leading-zero blanking: digit i (i>0) is blanked when shadow blank_lz=1 and shadow nibbles NUM_DIGITS-1 down to i are all 0. Digit 0 is never LZ-blanked.
- Visibility: vis = shadow digit_en[cur] AND NOT lz_blank[cur] AND lit_pwm (AND blink_on, when the feature is compiled in).
- Segment encoding: bit7=a .. bit1=g, bit0=dp; active-high.
  - 0:FC 1:60 2:DA 3:F2 4:66 5:B6 6:BE 7:E0
  - 8:FE 9:F6 A:EE B:3E C:9C D:7A E:9E F:8E
  - dp bit ORed from shadow dp_mask[cur].
- Outputs, all registered; one clk latency from a cur/pwm_cnt change:
  - an = vis ? (1<<cur) : 0.
  - cur >= NUM_DIGITS/2: seg = pattern when vis, else 0; seg1 = 0.
  - Otherwise: seg1 = pattern when vis, else 0; seg = 0.
  - The inactive bus is always driven 0 (no hold), so no ghosting.
- dp on an LZ-blanked or disabled digit is also dark.

Optional Feature:
- SEG7_BLINK_EN defined:
  - A frame counter counts frame_done pulses 0..BLINK_FRAMES-1 and toggles blink_on (reset value 1) on wrap.
  - Digits with blink_mask[i]=1 are dark while blink_on=0.
  - blink_mask is sampled live, not snapshotted.
- SEG7_BLINK_EN undefined:
  - No frame counter is built; blink_on is constant 1.
  - blink_mask is unused; the port remains present.

Test Plan (NUM_DIGITS=8, DIV_MAX=4, BLINK_FRAMES=2):
- Reset mid-scan:
  - Stimulus: assert rst for 1 cycle while cur=5.
  - Response: an=0, seg=0 and seg1=0 the next cycle; first frame dark; first frame_done 32 cycles after rst release.
- Basic scan:
  - Stimulus: show_data=0x89ABCDEF, brightness=15, digit_en=FF, dp_mask=00.
  - Response, second frame: an=01 with seg1=8E and seg=00; an=80 with seg=FE and seg1=00. Each digit lasts 4 cycles.
- Snapshot:
  - Stimulus: change show_data to 0x00000001 mid-frame.
  - Response: the current frame still shows the old value; the change appears only after frame_done.
- Leading-zero blanking:
  - Stimulus: blank_lz=1, show_data=0x00000120, dp_mask=01.
  - Response: digits 3..7 have an=0; digit 2 shows 60; digit 0 shows FC|01=FD.
- PWM:
  - Stimulus: brightness=3.
  - Response: an is nonzero on exactly 4 of every 16 cycles (pwm_cnt 0..3); brightness=0 gives 1 of 16.
- Blink (SEG7_BLINK_EN):
  - Stimulus: blink_mask=01.
  - Response: digit 0 dark for 2 frames, lit for 2, repeating; other digits unaffected. Without the macro, digit 0 is always lit.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner for NUM_DIGITS hex digits on two segment buses.
// Upper half of the digits drives seg, lower half drives seg1. Inputs are
// snapshotted once per scan frame so a frame never shows a mix of old and new data.
// Optional blinking is compiled in with the SEG7_BLINK_EN macro.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned DIV_MAX      = 50000,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   show_data,
  input  logic [NUM_DIGITS-1:0]     dp_mask,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      blank_lz,
  input  logic [3:0]                brightness,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  output logic [7:0]                seg,
  output logic [7:0]                seg1,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int unsigned DivW = $clog2(DIV_MAX);
  localparam int unsigned CurW = $clog2(NUM_DIGITS);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV_MAX - 1);
  localparam logic [CurW-1:0] CurLast = CurW'(NUM_DIGITS - 1);
  localparam logic [CurW-1:0] CurHalf = CurW'(NUM_DIGITS / 2);

  logic [DivW-1:0]         div_cnt_q;
  logic [CurW-1:0]         cur_q;
  logic [3:0]              pwm_cnt_q;
  logic                    tick;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] data_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    blank_lz_q;
  logic                    frame_done_q;

  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_above;
  logic                    lit_pwm;
  logic                    blink_ok;
  logic                    vis;
  logic [3:0]              nib;
  logic [7:0]              pat;
  logic [7:0]              seg_d, seg1_d;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [7:0]              seg_q, seg1_q;
  logic [NUM_DIGITS-1:0]   an_q;

  assign tick      = (div_cnt_q == DivLast);
  assign frame_end = tick && (cur_q == CurLast);

  // Active-high segment pattern, bit7 = a down to bit1 = g, bit0 (dp) left clear.
  function automatic logic [7:0] seg_pat(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hFC;
      4'h1: p = 8'h60;
      4'h2: p = 8'hDA;
      4'h3: p = 8'hF2;
      4'h4: p = 8'h66;
      4'h5: p = 8'hB6;
      4'h6: p = 8'hBE;
      4'h7: p = 8'hE0;
      4'h8: p = 8'hFE;
      4'h9: p = 8'hF6;
      4'hA: p = 8'hEE;
      4'hB: p = 8'h3E;
      4'hC: p = 8'h9C;
      4'hD: p = 8'h7A;
      4'hE: p = 8'h9E;
      default: p = 8'h8E;
    endcase
    return p;
  endfunction

  // Prescaler, digit counter and free-running PWM counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      cur_q     <= '0;
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 4'd1;
      div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
      if (tick) begin
        cur_q <= (cur_q == CurLast) ? '0 : cur_q + 1'b1;
      end
    end
  end

  // Frame snapshot of the display inputs, taken as the last digit slot ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q       <= '0;
      dp_q         <= '0;
      en_q         <= '0;
      blank_lz_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (frame_end) begin
        data_q     <= show_data;
        dp_q       <= dp_mask;
        en_q       <= digit_en;
        blank_lz_q <= blank_lz;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int unsigned BlkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BlkW-1:0] BlkLast = BlkW'(BLINK_FRAMES - 1);

  logic [BlkW-1:0] blk_cnt_q;
  logic            blink_on_q;

  // Frame counter toggles the blink phase every BLINK_FRAMES completed frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q  <= '0;
      blink_on_q <= 1'b1;
    end else if (frame_done_q) begin
      if (blk_cnt_q == BlkLast) begin
        blk_cnt_q  <= '0;
        blink_on_q <= ~blink_on_q;
      end else begin
        blk_cnt_q <= blk_cnt_q + 1'b1;
      end
    end
  end

  assign blink_ok = blink_on_q | ~blink_mask[cur_q];
`else
  logic unused_blink_mask;
  assign unused_blink_mask = ^blink_mask;
  assign blink_ok          = 1'b1;
`endif

  // Leading-zero mask, visibility and segment pattern for the current digit.
  always_comb begin
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above  = zero_above & (data_q[4*i +: 4] == 4'h0);
      lz_blank[i] = blank_lz_q & zero_above & (i != 0);
    end
    lit_pwm = (pwm_cnt_q <= brightness);
    vis     = en_q[cur_q] & ~lz_blank[cur_q] & lit_pwm & blink_ok;
    nib     = data_q[{cur_q, 2'b00} +: 4];
    pat     = vis ? (seg_pat(nib) | {7'b0, dp_q[cur_q]}) : 8'h00;
    an_d    = '0;
    an_d[cur_q] = vis;
    // Inactive bus is forced dark so nothing ghosts onto the other group.
    seg_d   = (cur_q >= CurHalf) ? pat : 8'h00;
    seg1_d  = (cur_q >= CurHalf) ? 8'h00 : pat;
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q   <= '0;
      seg_q  <= '0;
      seg1_q <= '0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      seg1_q <= seg1_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign seg1       = seg1_q;
  assign frame_done = frame_done_q;

endmodule
